// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : weight_loader
//  Description : Write side of the weight store. Accepts a framed byte stream
//                (START_BYTE, DEPTH weights, optional checksum byte) over a
//                valid/ready handshake and fills a DEPTH x 8-bit weight RAM.
//                A registered read port with 1-cycle latency feeds the
//                inference datapath.
//                Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN
//                  defined   -> trailing checksum byte required (CHECK state)
//                  undefined -> frame completes after the DEPTH-th weight
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_loader #(
  parameter int         DEPTH      = 784,
  parameter int         AW         = $clog2(DEPTH),
  parameter logic [7:0] START_BYTE = 8'hA5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    data_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          clear_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic [AW:0]   count_o,
  output logic          done_o,
  output logic          error_o
);

  // Last weight index of a frame, and the frame length, at count width.
  localparam logic [AW:0] C_LAST  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DONE  = 3'd3
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [AW:0] r_count;
  logic [AW:0] w_count_nxt;
  logic        w_wr_en;
  logic        w_accept;
  logic [7:0]  r_mem [DEPTH];

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
  logic [7:0]  w_sum_nxt;
`endif

  // Ready depends on state only, never on valid_i.
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  assign ready_o = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_CHECK);
  assign error_o = (r_state == S_ERROR);
`else
  assign ready_o = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign error_o = 1'b0;
`endif
  assign done_o   = (r_state == S_DONE);
  assign count_o  = r_count;
  assign w_accept = valid_i && ready_o;

  // Next-state, counter and checksum update; clear_i overrides any accepted byte.
  always_comb begin
    w_next_state = r_state;
    w_count_nxt  = r_count;
    w_wr_en      = 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    w_sum_nxt    = r_sum;
`endif
    if (clear_i) begin
      w_next_state = S_IDLE;
      w_count_nxt  = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      w_sum_nxt    = '0;
`endif
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (data_i == START_BYTE) begin
            w_next_state = S_LOAD;
            w_count_nxt  = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            w_sum_nxt    = '0;
`endif
          end
        end
        S_LOAD: begin
          w_wr_en     = 1'b1;
          w_count_nxt = r_count + 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          w_sum_nxt   = r_sum + data_i;
          if (r_count == C_LAST) w_next_state = S_CHECK;
`else
          if (r_count == C_LAST) w_next_state = S_DONE;
`endif
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        S_CHECK: begin
          w_next_state = (data_i == r_sum) ? S_DONE : S_ERROR;
        end
`endif
        default: ;
      endcase
    end
  end

  // State, count and checksum registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_count <= '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      r_count <= w_count_nxt;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      r_sum   <= w_sum_nxt;
`endif
    end
  end

  // Weight RAM write port; contents survive reset and clear.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[r_count[AW-1:0]] <= data_i;
  end

  // Registered read port; old data on a same-address write, zero beyond DEPTH.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_o <= '0;
    end else if ({1'b0, rd_addr_i} < C_DEPTH) begin
      rd_data_o <= r_mem[rd_addr_i];
    end else begin
      rd_data_o <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_loader
//  Description : Self-checking bench for weight_loader. A DEPTH=4 instance
//                covers framing, handshake, clear and reset corners; a
//                DEPTH=784 instance covers a full-size frame and the
//                out-of-range read. Works with WEIGHT_LOADER_CHECKSUM_EN
//                either defined or undefined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_loader;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  // Small instance (DEPTH = 4)
  logic [7:0] s_data;
  logic       s_valid, s_clear, s_ready, s_done, s_err;
  logic [1:0] s_addr;
  logic [7:0] s_rd;
  logic [2:0] s_count;

  // Full-size instance (DEPTH = 784)
  logic [7:0]  b_data;
  logic        b_valid, b_clear, b_ready, b_done, b_err;
  logic [9:0]  b_addr;
  logic [7:0]  b_rd;
  logic [10:0] b_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  weight_loader #(.DEPTH(4)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .data_i(s_data), .valid_i(s_valid),
    .ready_o(s_ready), .clear_i(s_clear), .rd_addr_i(s_addr),
    .rd_data_o(s_rd), .count_o(s_count), .done_o(s_done), .error_o(s_err)
  );

  weight_loader #(.DEPTH(784)) u_big (
    .clk_i(clk), .rst_ni(rst_n), .data_i(b_data), .valid_i(b_valid),
    .ready_o(b_ready), .clear_i(b_clear), .rd_addr_i(b_addr),
    .rd_data_o(b_rd), .count_o(b_count), .done_o(b_done), .error_o(b_err)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_done;
    logic [2:0] exp_count;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one byte for exactly one cycle (inputs change on negedge).
  task automatic s_send(input logic [7:0] b);
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic s_clear_pulse();
    s_clear = 1'b1;
    @(negedge clk);
    s_clear = 1'b0;
  endtask

  task automatic s_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    s_addr = a;
    @(negedge clk);
    chk(name, {24'd0, s_rd}, {24'd0, exp});
  endtask

  task automatic b_read(input logic [9:0] a, input logic [7:0] exp, input string name);
    b_addr = a;
    @(negedge clk);
    chk(name, {24'd0, b_rd}, {24'd0, exp});
  endtask

  initial begin
    logic [7:0] sum;

    rst_n = 1'b0;
    s_data = '0; s_valid = 1'b0; s_clear = 1'b0; s_addr = '0;
    b_data = '0; b_valid = 1'b0; b_clear = 1'b0; b_addr = '0;

    // Table: junk bytes, start byte, then 4 weights with valid toggled.
    tbl[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 8'h7F, 1'b1, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{1'b0, 8'h11, 1'b1, 1'b0, 3'd0};
    tbl[4]  = '{1'b1, 8'h11, 1'b1, 1'b0, 3'd1};
    tbl[5]  = '{1'b0, 8'h22, 1'b1, 1'b0, 3'd1};
    tbl[6]  = '{1'b1, 8'h22, 1'b1, 1'b0, 3'd2};
    tbl[7]  = '{1'b0, 8'h33, 1'b1, 1'b0, 3'd2};
    tbl[8]  = '{1'b1, 8'h33, 1'b1, 1'b0, 3'd3};
    tbl[9]  = '{1'b0, 8'h44, 1'b1, 1'b0, 3'd3};
    tbl[10] = '{1'b1, 8'h44, CK,   !CK,  3'd4};
    tbl[11] = '{1'b0, 8'h00, CK,   !CK,  3'd4};

    // Reset for two cycles.
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_done",  {31'd0, s_done},  32'd0);
    chk("rst_error", {31'd0, s_err},   32'd0);
    chk("rst_count", {29'd0, s_count}, 32'd0);
    chk("rst_rdata", {24'd0, s_rd},    32'd0);
    chk("rst_big_count", {21'd0, b_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      s_valid = tbl[i].valid;
      s_data  = tbl[i].data;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), {31'd0, s_ready}, {31'd0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_done", i),  {31'd0, s_done},  {31'd0, tbl[i].exp_done});
      chk($sformatf("tbl%0d_count", i), {29'd0, s_count}, {29'd0, tbl[i].exp_count});
    end
    s_valid = 1'b0;
    if (CK) begin
      s_send(8'hAA);   // 11+22+33+44 = AA
      chk("tbl_ck_done",  {31'd0, s_done},  32'd1);
      chk("tbl_ck_ready", {31'd0, s_ready}, 32'd0);
    end
    s_read(2'd0, 8'h11, "tbl_rd0");
    s_read(2'd1, 8'h22, "tbl_rd1");
    s_read(2'd2, 8'h33, "tbl_rd2");
    s_read(2'd3, 8'h44, "tbl_rd3");

    // clear_i collides with the third weight: it must not be written.
    s_clear_pulse();
    chk("clr_done",  {31'd0, s_done},  32'd0);
    chk("clr_ready", {31'd0, s_ready}, 32'd1);
    s_send(8'hA5);
    s_send(8'h01);
    s_send(8'h02);
    s_data = 8'h03; s_valid = 1'b1; s_clear = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_clear = 1'b0;
    chk("clr_hit_count", {29'd0, s_count}, 32'd0);
    s_send(8'h55);   // dropped in IDLE; would count in LOAD
    chk("clr_idle_count", {29'd0, s_count}, 32'd0);
    s_read(2'd0, 8'h01, "clr_rd0");
    s_read(2'd1, 8'h02, "clr_rd1");
    s_read(2'd2, 8'h33, "clr_rd2_kept");

    // Back-to-back frame with correct checksum 0A.
    s_data = 8'hA5; s_valid = 1'b1; @(negedge clk);
    s_data = 8'h01; @(negedge clk);
    s_data = 8'h02; @(negedge clk);
    s_data = 8'h03; @(negedge clk);
    s_data = 8'h04; @(negedge clk);
    chk("frm_done_before_ck", {31'd0, s_done}, {31'd0, !CK});
    s_data = 8'h0A; @(negedge clk);
    s_valid = 1'b0;
    chk("frm_done",  {31'd0, s_done},  32'd1);
    chk("frm_error", {31'd0, s_err},   32'd0);
    chk("frm_count", {29'd0, s_count}, 32'd4);
    s_read(2'd0, 8'h01, "frm_rd0");
    s_read(2'd1, 8'h02, "frm_rd1");
    s_read(2'd2, 8'h03, "frm_rd2");
    s_read(2'd3, 8'h04, "frm_rd3");

    // Bad checksum: 10+20+30+F0 = 50, host sends 01.
    s_clear_pulse();
    s_send(8'hA5); s_send(8'h10); s_send(8'h20); s_send(8'h30); s_send(8'hF0);
    s_send(8'h01);
    chk("bad_error", {31'd0, s_err},   {31'd0, CK});
    chk("bad_done",  {31'd0, s_done},  {31'd0, !CK});
    chk("bad_ready", {31'd0, s_ready}, 32'd0);
    s_clear_pulse();
    chk("bad_clr_error", {31'd0, s_err}, 32'd0);

    // Reset mid-frame: RAM keeps the written byte, start byte required again.
    s_send(8'hA5); s_send(8'h77);
    chk("mid_count", {29'd0, s_count}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", {29'd0, s_count}, 32'd0);
    chk("mid_rst_rdata", {24'd0, s_rd},    32'd0);
    rst_n = 1'b1;
    s_send(8'h66);
    chk("mid_idle_count", {29'd0, s_count}, 32'd0);
    s_read(2'd0, 8'h77, "mid_rd0_kept");

    // Full-size frame of i mod 256.
    sum = 8'h00;
    b_data = 8'hA5; b_valid = 1'b1; @(negedge clk);
    for (int i = 0; i < 784; i++) begin
      b_data = 8'(i);
      sum    = sum + 8'(i);
      @(negedge clk);
    end
    if (CK) begin
      b_data = sum;
      @(negedge clk);
    end
    b_valid = 1'b0;
    chk("big_done",  {31'd0, b_done},  32'd1);
    chk("big_error", {31'd0, b_err},   32'd0);
    chk("big_count", {21'd0, b_count}, 32'd784);
    chk("big_ready", {31'd0, b_ready}, 32'd0);
    b_read(10'd783, 8'h0F, "big_rd783");
    b_read(10'd784, 8'h00, "big_rd784");
    b_read(10'd300, 8'h2C, "big_rd300");
    b_read(10'd1,   8'h01, "big_rd1");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
